// File: rtl/epp_host_pkg.sv
// ----------------------------------------------------------------
// epp_host_pkg : op codes and FSM state encodings for epp_host_ctrl
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package epp_host_pkg;

  localparam logic [1:0] OP_ADDR_WR = 2'b00;
  localparam logic [1:0] OP_DATA_WR = 2'b01;
  localparam logic [1:0] OP_DATA_RD = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_SETUP   = 3'd2,
    S_STROBE  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_RECOVER = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/epp_sync2.sv
// ----------------------------------------------------------------
// epp_sync2 : two-flop synchroniser for the asynchronous WAIT line
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module epp_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/epp_host_ctrl.sv
// ----------------------------------------------------------------
// epp_host_ctrl : host-side EPP initiator (addr write, data write, data read)
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module epp_host_ctrl
  import epp_host_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 1023,
  parameter int CNT_W        = 10
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [1:0] cmdOp_in,
  input  logic [7:0] cmdData_in,
  input  logic       cmdValid_in,
  output logic       cmdReady_out,
  output logic [7:0] rspData_out,
  output logic       rspErr_out,
  output logic       rspValid_out,
  inout  wire  [7:0] eppData_io,
  output logic       eppAddrStb_out,
  output logic       eppDataStb_out,
  output logic       eppWrite_out,
  input  logic       eppWait_in
);

  localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       r_op, w_op;
  logic [7:0]       r_wdata, w_wdata;
  logic [7:0]       r_rdata, w_rdata;
  logic             r_err, w_err;
  logic             r_addr_stb, w_addr_stb;
  logic             r_data_stb, w_data_stb;
  logic             r_write, w_write;
  logic             r_data_oe, w_data_oe;
  logic             r_rsp_valid, w_rsp_valid;
  logic             r_rsp_err, w_rsp_err;
  logic [7:0]       r_rsp_data, w_rsp_data;
  logic             w_wait_sync;
  logic             w_accept;

  epp_sync2 u_wait_sync (
    .i_clk   (clk_in),
    .i_rst_n (reset_in),
    .i_d     (eppWait_in),
    .o_q     (w_wait_sync)
  );

  assign w_accept = cmdValid_in && (r_state == S_IDLE);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_ADDR_WR;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
      r_err       <= 1'b0;
      r_addr_stb  <= 1'b1;
      r_data_stb  <= 1'b1;
      r_write     <= 1'b1;
      r_data_oe   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_op        <= w_op;
      r_wdata     <= w_wdata;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
      r_addr_stb  <= w_addr_stb;
      r_data_stb  <= w_data_stb;
      r_write     <= w_write;
      r_data_oe   <= w_data_oe;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_data  <= w_rsp_data;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_op        = r_op;
    w_wdata     = r_wdata;
    w_rdata     = r_rdata;
    w_err       = r_err;
    w_addr_stb  = r_addr_stb;
    w_data_stb  = r_data_stb;
    w_write     = r_write;
    w_data_oe   = r_data_oe;
    w_rsp_valid = 1'b0;
    w_rsp_err   = r_rsp_err;
    w_rsp_data  = r_rsp_data;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op    = cmdOp_in;
          w_wdata = cmdData_in;
          w_rdata = 8'h00;
          w_err   = 1'b0;
          w_cnt   = '0;
          if (cmdOp_in == OP_RSVD) begin
            w_err   = 1'b1;
            w_state = S_DONE;
          end else if (cmdOp_in == OP_DATA_RD) begin
            w_state = S_SETUP;
          end else begin
            w_write = 1'b0;
            w_state = S_TURN;
          end
        end
      end

      // Bus drive starts a cycle after the direction line so the peripheral
      // has already released the data lines.
      S_TURN: begin
        w_data_oe = 1'b1;
        w_state   = S_SETUP;
      end

      S_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_cnt = '0;
          if (r_op == OP_ADDR_WR) begin
            w_addr_stb = 1'b0;
          end else begin
            w_data_stb = 1'b0;
          end
          w_state = S_STROBE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_STROBE: begin
        if (w_wait_sync) begin
          if (r_op == OP_DATA_RD) begin
            w_rdata = eppData_io;
          end
          w_addr_stb = 1'b1;
          w_data_stb = 1'b1;
          w_cnt      = '0;
          w_state    = S_RELEASE;
        end else if (r_cnt == c_TMO_LAST) begin
          w_err      = 1'b1;
          w_addr_stb = 1'b1;
          w_data_stb = 1'b1;
          w_cnt      = '0;
          w_state    = S_RELEASE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (!w_wait_sync) begin
          w_cnt   = '0;
          w_state = S_DONE;
        end else if (r_cnt == c_TMO_LAST) begin
          w_err   = 1'b1;
          w_cnt   = '0;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        w_data_oe   = 1'b0;
        w_rsp_valid = 1'b1;
        w_rsp_err   = r_err;
        w_rsp_data  = r_err ? 8'h00 : r_rdata;
        w_state     = S_RECOVER;
      end

      // Direction returns to read one cycle after the host stopped driving.
      S_RECOVER: begin
        w_write = 1'b1;
        w_state = S_IDLE;
      end

      default: begin
        w_addr_stb = 1'b1;
        w_data_stb = 1'b1;
        w_data_oe  = 1'b0;
        w_write    = 1'b1;
        w_cnt      = '0;
        w_state    = S_IDLE;
      end
    endcase
  end

  assign cmdReady_out   = (r_state == S_IDLE);
  assign rspValid_out   = r_rsp_valid;
  assign rspErr_out     = r_rsp_err;
  assign rspData_out    = r_rsp_data;
  assign eppAddrStb_out = r_addr_stb;
  assign eppDataStb_out = r_data_stb;
  assign eppWrite_out   = r_write;
  assign eppData_io     = r_data_oe ? r_wdata : 8'bzzzz_zzzz;

endmodule

`default_nettype wire

// File: tb/tb_epp_host_ctrl.sv
// ----------------------------------------------------------------
// tb_epp_host_ctrl : directed bench with a behavioural EPP peripheral
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_epp_host_ctrl;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [1:0] cmdOp_in;
  logic [7:0] cmdData_in;
  logic       cmdValid_in;
  logic       cmdReady_out;
  logic [7:0] rspData_out;
  logic       rspErr_out;
  logic       rspValid_out;
  wire  [7:0] eppData;
  logic       eppAddrStb_out;
  logic       eppDataStb_out;
  logic       eppWrite_out;

  int n_cmp = 0;
  int n_mis = 0;

  // peripheral model
  logic       p_wait  = 1'b0;
  logic [7:0] p_addr  = 8'h00;
  logic [7:0] p_wdata = 8'h00;
  logic [7:0] p_rdata = 8'h00;
  int         stb_cnt = 0;
  int         wait_dly = 3;
  logic       never_wait = 1'b0;

  // monitor counters
  int addr_falls = 0;
  int data_falls = 0;
  int data_low   = 0;
  int wr_low     = 0;
  logic prev_addr = 1'b1;
  logic prev_data = 1'b1;

  logic [8:0] rsp_q[$];
  logic [8:0] exp_q[$];

  epp_host_ctrl #(
    .SETUP_CYCLES (2),
    .TIMEOUT      (15),
    .CNT_W        (10)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .cmdOp_in       (cmdOp_in),
    .cmdData_in     (cmdData_in),
    .cmdValid_in    (cmdValid_in),
    .cmdReady_out   (cmdReady_out),
    .rspData_out    (rspData_out),
    .rspErr_out     (rspErr_out),
    .rspValid_out   (rspValid_out),
    .eppData_io     (eppData),
    .eppAddrStb_out (eppAddrStb_out),
    .eppDataStb_out (eppDataStb_out),
    .eppWrite_out   (eppWrite_out),
    .eppWait_in     (p_wait)
  );

  always #5 clk = ~clk;

  assign eppData = (eppWrite_out && !eppDataStb_out) ? p_rdata : 8'bzzzz_zzzz;

  always @(posedge clk) begin
    if (!eppAddrStb_out || !eppDataStb_out) begin
      if (!never_wait && stb_cnt == wait_dly) begin
        p_wait <= 1'b1;
        if (!eppWrite_out && !eppAddrStb_out) p_addr  <= eppData;
        if (!eppWrite_out && !eppDataStb_out) p_wdata <= eppData;
      end
      stb_cnt <= stb_cnt + 1;
    end else begin
      stb_cnt <= 0;
      p_wait  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus/strobe rules and response capture, sampled on the falling edge.
  always @(negedge clk) begin
    if (prev_addr && !eppAddrStb_out) addr_falls++;
    if (prev_data && !eppDataStb_out) data_falls++;
    if (!eppDataStb_out) data_low++;
    if (!eppWrite_out) wr_low++;
    prev_addr = eppAddrStb_out;
    prev_data = eppDataStb_out;
    if (rspValid_out) rsp_q.push_back({rspErr_out, rspData_out});
    if (reset_in) begin
      if (dut.r_data_oe) check("oe_implies_write_low", {31'd0, eppWrite_out}, 32'd0);
      if (!eppAddrStb_out) check("one_strobe_only", {31'd0, eppDataStb_out}, 32'd1);
      if (cmdReady_out)
        check("idle_bus_quiet", {29'd0, eppAddrStb_out, eppDataStb_out, dut.r_data_oe}, 32'd6);
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                        output logic [7:0] rd, output logic er);
    int k;
    k = 0;
    while (!cmdReady_out && k < 100) begin @(negedge clk); k++; end
    check("ready_before_cmd", {31'd0, cmdReady_out}, 32'd1);
    cmdOp_in    = op;
    cmdData_in  = d;
    cmdValid_in = 1'b1;
    @(negedge clk);
    cmdValid_in = 1'b0;
    k = 0;
    while (!rspValid_out && k < 200) begin @(negedge clk); k++; end
    check("rsp_seen", {31'd0, rspValid_out}, 32'd1);
    rd = rspData_out;
    er = rspErr_out;
    @(negedge clk);
  endtask

  logic [7:0] rd;
  logic       er;
  int         k0, a0, d0, w0;
  logic [1:0] rop;
  logic [7:0] rdat;

  initial begin
    reset_in    = 1'b0;
    cmdOp_in    = 2'b00;
    cmdData_in  = 8'h00;
    cmdValid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmdReady_out}, 32'd1);
    check("rst_rsp", {22'd0, rspValid_out, rspErr_out, rspData_out}, 32'd0);
    check("rst_epp", {29'd0, eppAddrStb_out, eppDataStb_out, eppWrite_out}, 32'd7);
    reset_in = 1'b1;
    @(negedge clk);

    // 1: address write
    wait_dly = 3;
    a0 = addr_falls; d0 = data_falls;
    do_cmd(2'b00, 8'h05, rd, er);
    check("t1_addr_stb_once", addr_falls - a0, 1);
    check("t1_no_data_stb", data_falls - d0, 0);
    check("t1_periph_addr", {24'd0, p_addr}, 32'h05);
    check("t1_rsp", {23'd0, er, rd}, 32'h000);

    // 2: data write then read
    do_cmd(2'b01, 8'hA5, rd, er);
    check("t2_periph_wdata", {24'd0, p_wdata}, 32'hA5);
    check("t2_wr_rsp", {23'd0, er, rd}, 32'h000);
    p_rdata = 8'h3C;
    do_cmd(2'b10, 8'h00, rd, er);
    check("t2_rd_rsp", {23'd0, er, rd}, 32'h03C);

    // 3: peripheral never answers
    never_wait = 1'b1;
    data_low = 0;
    do_cmd(2'b10, 8'h00, rd, er);
    check("t3_strobe_low_cycles", data_low, 15);
    check("t3_rsp", {23'd0, er, rd}, 32'h100);
    check("t3_back_idle", {31'd0, cmdReady_out}, 32'd1);
    never_wait = 1'b0;

    // 4: reserved op
    a0 = addr_falls; d0 = data_falls; w0 = wr_low;
    cmdOp_in = 2'b11; cmdData_in = 8'hFF; cmdValid_in = 1'b1;
    @(negedge clk);
    cmdValid_in = 1'b0;
    check("t4_no_rsp_yet", {31'd0, rspValid_out}, 32'd0);
    @(negedge clk);
    check("t4_rsp", {22'd0, rspValid_out, rspErr_out, rspData_out}, 32'h300);
    check("t4_no_bus", (addr_falls - a0) + (data_falls - d0) + (wr_low - w0), 0);
    @(negedge clk);

    // 5: reset during write strobe
    never_wait = 1'b1;
    cmdOp_in = 2'b01; cmdData_in = 8'h77; cmdValid_in = 1'b1;
    @(negedge clk);
    cmdValid_in = 1'b0;
    k0 = 0;
    while (eppDataStb_out && k0 < 20) begin @(negedge clk); k0++; end
    check("t5_reached_strobe", {31'd0, eppDataStb_out}, 32'd0);
    reset_in = 1'b0;
    #1;
    check("t5_epp_released", {28'd0, eppAddrStb_out, eppDataStb_out, eppWrite_out, dut.r_data_oe}, 32'hE);
    check("t5_ready", {30'd0, cmdReady_out, rspValid_out}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b1;
    never_wait = 1'b0;
    @(negedge clk);
    do_cmd(2'b00, 8'h2B, rd, er);
    check("t5_after_addr", {24'd0, p_addr}, 32'h2B);
    check("t5_after_rsp", {23'd0, er, rd}, 32'h000);

    // 6: back-to-back commands with cmdValid held high
    wait_dly = 1;
    p_rdata = 8'h5A;
    rsp_q.delete();
    for (int i = 0; i < 16; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      cmdOp_in = rop; cmdData_in = rdat; cmdValid_in = 1'b1;
      if (rop == 2'b11)      exp_q.push_back(9'h100);
      else if (rop == 2'b10) exp_q.push_back(9'h05A);
      else                   exp_q.push_back(9'h000);
      k0 = 0;
      while (!cmdReady_out && k0 < 200) begin @(negedge clk); k0++; end
      check("t6_ready", {31'd0, cmdReady_out}, 32'd1);
      @(negedge clk);
    end
    cmdValid_in = 1'b0;
    k0 = 0;
    while (rsp_q.size() < 16 && k0 < 400) begin @(negedge clk); k0++; end
    repeat (5) @(negedge clk);
    check("t6_rsp_count", rsp_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < rsp_q.size()) check($sformatf("t6_rsp%0d", i), {23'd0, rsp_q[i]}, {23'd0, exp_q[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
